// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button front end: button indices, the
// arbiter state encoding and a lowest-set-bit helper.
package btn_conditioner_pkg;

  localparam int BTN_CENTRE = 0;
  localparam int BTN_UP     = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_DOWN   = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  // Keeps only the lowest set bit, so the result is one-hot or zero.
  function automatic logic [3:0] lowest_one(input logic [3:0] vec);
    return vec & (~vec + 4'd1);
  endfunction

endpackage

// File: rtl/btn_conditioner_debounce_cell.sv
// Single-bit button cleaner: 2-flop synchroniser followed by a debounce
// counter that flips the clean level after a sustained mismatch.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean
);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // Mismatch has persisted for the full window: accept the new level.
        clean <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Button front end: per-button debounce, rising-edge pulses and a
// direction arbiter that presents at most one movement direction.
//
//   state    | meaning
//   ARB_IDLE | no direction selected, move_dir = 0
//   ARB_HOLD | sel holds the active direction (newest press wins)
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int N_BTN           = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_BTN-1:0] btn_rise,
  output logic             reset_req,
  output logic [3:0]       move_dir
);

  logic [N_BTN-1:0] btn_clean_d;
  arb_state_t       state;
  logic [3:0]       sel;
  logic [3:0]       dir_rise;
  logic [3:0]       dir_held;
  logic [3:0]       new_rise;

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .clean(btn_clean[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_clean_d <= '0;
      btn_rise    <= '0;
    end else begin
      btn_clean_d <= btn_clean;
      btn_rise    <= btn_clean & ~btn_clean_d;
    end
  end

  assign reset_req = btn_rise[BTN_CENTRE];

  assign dir_rise = btn_rise[BTN_DOWN:BTN_UP];
  assign dir_held = btn_clean[BTN_DOWN:BTN_UP];
  assign new_rise = dir_rise & ~sel;
  assign move_dir = sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      sel   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|dir_rise) begin
            sel   <= lowest_one(dir_rise);
            state <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          // A fresh press outranks a release happening in the same cycle.
          if (|new_rise) begin
            sel <= lowest_one(new_rise);
          end else if (~|(dir_held & sel)) begin
            if (|dir_held) begin
              sel <= lowest_one(dir_held);
            end else begin
              sel   <= '0;
              state <= ARB_IDLE;
            end
          end
        end
        default: begin
          sel   <= '0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random button activity,
// checked every cycle against a window-based reference model.
module tb_btn_conditioner;

  localparam int D = 4;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_clean;
  logic [N-1:0] btn_rise;
  logic         reset_req;
  logic [3:0]   move_dir;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20),
    .N_BTN          (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_clean(btn_clean),
    .btn_rise (btn_rise),
    .reset_req(reset_req),
    .move_dir (move_dir)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a button's clean level flips once the last D synchronised
  // samples all disagree with it; the arbiter tracks a button index (0 = none).
  logic [N-1:0] m_s1, m_s2, m_clean, m_clean_d, m_rise;
  logic [N-1:0] m_win [D];
  int           m_sel;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_clean = '0; m_clean_d = '0; m_rise = '0; m_sel = 0;
    for (int k = 0; k < D; k++) m_win[k] = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] nclean;
    logic [3:0]   r;
    int           nsel;
    bit           all_diff;
    r = m_rise[4:1];
    if (m_sel != 0) r[m_sel-1] = 1'b0;
    nsel = m_sel;
    if (r != 0) nsel = lowest_idx(r);
    else if (m_sel != 0 && !m_clean[m_sel]) nsel = lowest_idx(m_clean[4:1]);
    for (int k = D - 1; k > 0; k--) m_win[k] = m_win[k-1];
    m_win[0] = m_s2;
    nclean = m_clean;
    for (int b = 0; b < N; b++) begin
      all_diff = 1'b1;
      for (int k = 0; k < D; k++) if (m_win[k][b] == m_clean[b]) all_diff = 1'b0;
      if (all_diff) nclean[b] = ~m_clean[b];
    end
    m_rise    = m_clean & ~m_clean_d;
    m_clean_d = m_clean;
    m_clean   = nclean;
    m_s2      = m_s1;
    m_s1      = btn_raw;
    m_sel     = nsel;
  endtask

  function automatic logic [3:0] m_move();
    return (m_sel == 0) ? 4'b0000 : 4'(1 << (m_sel - 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    else m_reset();
    #1;
    check_val("btn_clean", 32'(btn_clean), 32'(m_clean));
    check_val("btn_rise", 32'(btn_rise), 32'(m_rise));
    check_val("reset_req", 32'(reset_req), 32'(m_rise[0]));
    check_val("move_dir", 32'(move_dir), 32'(m_move()));
    check_val("move_onehot", 32'($countones(move_dir) <= 1), 32'd1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int pulses;
  int hold;

  initial begin
    m_reset();
    btn_raw = 5'b11111;
    ticks(3);
    check_val("rst_hold_clean", 32'(btn_clean), 32'd0);
    check_val("rst_hold_move", 32'(move_dir), 32'd0);
    #2 rst = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 5) check_val("rel_clean_c5", 32'(btn_clean), 32'd0);
      if (c == 6) check_val("rel_clean_c6", 32'(btn_clean), 32'h1f);
      if (c == 7) check_val("rel_rise_c7", 32'(btn_rise), 32'h1f);
      if (c == 8) check_val("rel_move_c8", 32'(move_dir), 32'b0001);
      if (c == 9) check_val("rel_rise_c9", 32'(btn_rise), 32'd0);
    end
    btn_raw = '0;
    ticks(12);
    check_val("all_released", 32'(move_dir), 32'd0);

    // Glitch rejection, then a real right press.
    btn_raw[3] = 1'b1;
    ticks(3);
    btn_raw[3] = 1'b0;
    ticks(10);
    check_val("glitch_clean", 32'(btn_clean), 32'd0);
    check_val("glitch_move", 32'(move_dir), 32'd0);
    btn_raw[3] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 5) check_val("right_clean_c5", 32'(btn_clean[3]), 32'd0);
      if (c == 6) check_val("right_clean_c6", 32'(btn_clean[3]), 32'd1);
      if (c == 8) check_val("right_move_c8", 32'(move_dir), 32'b0100);
    end

    // Newest press wins; release falls back to a still-held direction.
    btn_raw[1] = 1'b1;
    ticks(10);
    check_val("up_over_right", 32'(move_dir), 32'b0001);
    btn_raw[1] = 1'b0;
    ticks(10);
    check_val("back_to_right", 32'(move_dir), 32'b0100);
    btn_raw[3] = 1'b0;
    ticks(10);
    check_val("right_released", 32'(move_dir), 32'd0);

    // Simultaneous left+down.
    btn_raw = 5'b10100;
    ticks(10);
    check_val("simul_left", 32'(move_dir), 32'b0010);
    btn_raw = 5'b10000;
    ticks(10);
    check_val("left_released", 32'(move_dir), 32'b1000);

    // Centre press: single reset_req pulse, move_dir undisturbed.
    btn_raw = 5'b10001;
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (reset_req) pulses++;
    end
    check_val("reset_req_pulses", 32'(pulses), 32'd1);
    check_val("centre_move", 32'(move_dir), 32'b1000);

    // Async reset mid-count while left is selected and down is debouncing.
    btn_raw = 5'b00100;
    ticks(10);
    check_val("left_only", 32'(move_dir), 32'b0010);
    btn_raw = 5'b10100;
    ticks(4);
    #2 rst = 1'b0;
    #1;
    check_val("async_clean", 32'(btn_clean), 32'd0);
    check_val("async_rise", 32'(btn_rise), 32'd0);
    check_val("async_move", 32'(move_dir), 32'd0);
    m_reset();
    ticks(2);
    #2 rst = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 5) check_val("restart_clean_c5", 32'(btn_clean), 32'd0);
      if (c == 6) check_val("restart_clean_c6", 32'(btn_clean), 32'b10100);
      if (c == 8) check_val("restart_move_c8", 32'(move_dir), 32'b0010);
    end

    // Random activity: mix of glitches and sustained presses.
    for (int it = 0; it < 400; it++) begin
      btn_raw = N'($urandom);
      hold = $urandom_range(1, 9);
      ticks(hold);
    end
    btn_raw = '0;
    ticks(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
